seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector. It is the next generation of the team's fixed 4-bit Mealy overlapping detector.
- Adds the following over that block:
  - pattern length set by parameter
  - pattern reloadable at run time
  - overlap and non-overlap modes selected at run time
  - input-valid qualifier
  - saturating match counter
- Sits between a serial receive front-end and control or status logic. The one-cycle match pulse triggers downstream actions; the count is read over the status bus.

Parameters:
- PAT_W, 4, pattern length in bits (legal range 2..32).
- PAT_INIT, 4'b1011 (PAT_W bits), pattern loaded at reset.
- CNT_W, 8, width of the match counter.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- seq_in  in  1  serial data bit.
- in_valid  in  1  seq_in is sampled only when this is 1.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- load_pat  in  1  load pat_in into the pattern register this cycle.
- pat_in  in  PAT_W  new pattern. Bit PAT_W-1 is the first bit received.
- clear_cnt  in  1  zero match_count and cnt_sat.
- match  out  1  registered one-cycle pulse: pattern completed on the previous valid bit.
- match_count  out  CNT_W  number of matches, saturating.
- cnt_sat  out  1  sticky; set when match_count reaches all-ones.

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - pattern register = PAT_INIT; history register = 0; fill counter = 0.
  - match = 0, match_count = 0, cnt_sat = 0.
  - reset overrides every other input.
- State:
  - hist: PAT_W-1 bits, the most recent valid bits received.
  - fill: 0..PAT_W, the number of valid bits accumulated since the last restart. Saturates at PAT_W.
- On a cycle with in_valid=1 and load_pat=0:
  - cand = {hist, seq_in}; hist shifts in seq_in; fill increments, saturating.
  - hit = 1 when (fill+1) >= PAT_W and cand == pattern.
- On a hit:
  - match = 1 on the next cycle (latency 1 clock after the final bit is sampled; same timing as the previous generation).
  - overlap=1: fill keeps saturating, so the tail of one match can begin the next.
  - overlap=0: fill is cleared to 0, so the next match needs PAT_W fresh bits.
- in_valid=0: hist, fill and pattern hold; match = 0 next cycle.
- match is high for exactly one cycle per hit. Back-to-back hits give back-to-back pulses.
- load_pat=1:
  - pattern <= pat_in; fill <= 0; hist <= 0; match = 0 next cycle.
  - load_pat has priority over in_valid. A bit presented in the same cycle is discarded.
- overlap may change at any time. It takes effect on the next valid bit; no restart.
- match_count:
  - increments by 1 on each hit when below 2^CNT_W-1.
  - at all-ones it holds and cnt_sat = 1.
  - clear_cnt=1 zeroes match_count and cnt_sat. clear_cnt wins over a same-cycle hit; the match pulse is still produced.
- Reset mid-stream discards a partial pattern; no match is produced for bits before reset.

Optional Feature:
- Macro SEQ_DET_MASK_EN.
- Defined:
  - adds input pat_mask_in [PAT_W] and an internal mask register (reset value all-ones), loaded together with pat_in on load_pat.
  - compare becomes ((cand ^ pattern) & mask) == 0. Mask bit 0 = don't-care.
- Not defined: no extra port; full exact compare.

Decomposition:
- Package seq_det_pkg:
  - default constants DEF_PAT_W = 4, DEF_PAT_INIT = 4'b1011, DEF_CNT_W = 8.
  - mode encoding constants MODE_NONOVL = 1'b0, MODE_OVL = 1'b1.
- Sub-module seq_det_sat_cnt: parametrised CNT_W saturating counter with inc, clr (priority) and sticky sat output.

Test Plan:
- Default pattern 1011, overlap=1, in_valid=1, stream 1,0,1,1,0,1,1 → match pulses in the cycles after bit 4 and bit 7; match_count=2.
- Same stream with overlap=0 → single pulse after bit 4; match_count=1.
- Stream 1,0,(in_valid=0 for 3 cycles),1,1 → one match after the last valid bit; no pulse during the gap.
- load_pat with pat_in=4'b0110 mid-stream while in_valid=1 → that bit is discarded; the old pattern no longer matches; 0,1,1,0 then gives a pulse.
- CNT_W=2 with 4 matches → count goes 1,2,3,3 and cnt_sat=1. clear_cnt in the same cycle as a hit → count 0, match pulse still seen.
- reset asserted after bits 1,0,1, then bit 1 supplied → no match. All outputs are 0 in the cycle after reset.

Source files
------------

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants for the parametrised serial pattern detector
package seq_det_pkg;

  localparam int         DEF_PAT_W    = 4;
  localparam logic [3:0] DEF_PAT_INIT = 4'b1011;
  localparam int         DEF_CNT_W    = 8;

  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL    = 1'b1;

  // Width needed to hold a fill level of 0..pat_w inclusive.
  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// rtl/seq_det_sat_cnt.sv - saturating event counter with priority clear and sticky saturation flag
module seq_det_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
      sat   <= (count == (CNT_MAX - CNT_W'(1)));
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial pattern detector with reloadable pattern and match counter
// Optional don't-care mask compare is enabled by defining SEQ_DET_MASK_EN.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W    = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(DEF_PAT_INIT),
  parameter int               CNT_W    = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             seq_in,
  input  logic             in_valid,
  input  logic             overlap,
  input  logic             load_pat,
  input  logic [PAT_W-1:0] pat_in,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_W-1:0] pat_mask_in,
`endif
  input  logic             clear_cnt,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             cnt_sat
);

  localparam int             FW        = fill_w(PAT_W);
  localparam logic [FW-1:0]  FILL_FULL = FW'(PAT_W);
  localparam logic [FW-1:0]  FILL_LAST = FW'(PAT_W - 1);

  logic [PAT_W-1:0] pattern_q;
  logic [PAT_W-2:0] hist_q;
  logic [FW-1:0]    fill_q;
  logic [PAT_W-1:0] cand;
  logic             take_bit;
  logic             hit;

  assign take_bit = in_valid && !load_pat;
  assign cand     = {hist_q, seq_in};

`ifdef SEQ_DET_MASK_EN
  logic [PAT_W-1:0] mask_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      mask_q <= '1;
    end else if (load_pat) begin
      mask_q <= pat_mask_in;
    end
  end

  assign hit = take_bit && (fill_q >= FILL_LAST) && (((cand ^ pattern_q) & mask_q) == '0);
`else
  assign hit = take_bit && (fill_q >= FILL_LAST) && (cand == pattern_q);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      pattern_q <= PAT_INIT;
      hist_q    <= '0;
      fill_q    <= '0;
      match     <= 1'b0;
    end else begin
      match <= hit;
      if (load_pat) begin
        pattern_q <= pat_in;
        hist_q    <= '0;
        fill_q    <= '0;
      end else if (in_valid) begin
        hist_q <= cand[PAT_W-2:0];
        // Non-overlap restarts accumulation so the next match needs a full fresh pattern.
        if (hit && (overlap == MODE_NONOVL)) begin
          fill_q <= '0;
        end else if (fill_q != FILL_FULL) begin
          fill_q <= fill_q + FW'(1);
        end
      end
    end
  end

  seq_det_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (hit),
    .clr   (clear_cnt),
    .count (match_count),
    .sat   (cnt_sat)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - bench for seq_detector_param: directed plan plus random stream vs queue model
module tb_seq_detector_param;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       seq_in = 1'b0;
  logic       in_valid = 1'b0;
  logic       overlap = 1'b1;
  logic       load_pat = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       clear_cnt = 1'b0;
`ifdef SEQ_DET_MASK_EN
  logic [3:0] pat_mask_in = 4'b1111;
`endif

  logic       match_a, sat_a;
  logic [7:0] cnt_a;
  logic       match_b, sat_b;
  logic [1:0] cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  bit         win[$];
  logic [3:0] mpat = 4'b1011;
  int         mcnt_a = 0;
  int         mcnt_b = 0;
  bit         msat_a = 1'b0;
  bit         msat_b = 1'b0;

  always #5 clock = ~clock;

  seq_detector_param dut_a (
    .clock       (clock),
    .reset       (reset),
    .seq_in      (seq_in),
    .in_valid    (in_valid),
    .overlap     (overlap),
    .load_pat    (load_pat),
    .pat_in      (pat_in),
`ifdef SEQ_DET_MASK_EN
    .pat_mask_in (pat_mask_in),
`endif
    .clear_cnt   (clear_cnt),
    .match       (match_a),
    .match_count (cnt_a),
    .cnt_sat     (sat_a)
  );

  seq_detector_param #(
    .PAT_W    (4),
    .PAT_INIT (4'b1011),
    .CNT_W    (2)
  ) dut_b (
    .clock       (clock),
    .reset       (reset),
    .seq_in      (seq_in),
    .in_valid    (in_valid),
    .overlap     (overlap),
    .load_pat    (load_pat),
    .pat_in      (pat_in),
`ifdef SEQ_DET_MASK_EN
    .pat_mask_in (pat_mask_in),
`endif
    .clear_cnt   (clear_cnt),
    .match       (match_b),
    .match_count (cnt_b),
    .cnt_sat     (sat_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one clock of inputs, advance the model, then compare both instances after the edge.
  task automatic step(input bit rst, input bit v, input bit b, input bit ov,
                      input bit ld, input logic [3:0] p, input bit clr);
    bit         hit;
    logic [3:0] w;
    reset = rst; in_valid = v; seq_in = b; overlap = ov;
    load_pat = ld; pat_in = p; clear_cnt = clr;
    hit = 1'b0;
    if (rst) begin
      win.delete();
      mpat = 4'b1011;
      mcnt_a = 0; mcnt_b = 0; msat_a = 1'b0; msat_b = 1'b0;
    end else begin
      if (ld) begin
        mpat = p;
        win.delete();
      end else if (v) begin
        win.push_back(b);
        if (win.size() > 4) void'(win.pop_front());
        if (win.size() == 4) begin
          w = {win[0], win[1], win[2], win[3]};
          hit = (w == mpat);
        end
        if (hit && !ov) win.delete();
      end
      if (clr) begin
        mcnt_a = 0; mcnt_b = 0; msat_a = 1'b0; msat_b = 1'b0;
      end else if (hit) begin
        if (mcnt_a < 255) mcnt_a++;
        if (mcnt_a == 255) msat_a = 1'b1;
        if (mcnt_b < 3) mcnt_b++;
        if (mcnt_b == 3) msat_b = 1'b1;
      end
    end
    @(posedge clock);
    #1;
    chk("match_a", 32'(match_a), 32'(hit));
    chk("count_a", 32'(cnt_a), 32'(mcnt_a));
    chk("sat_a",   32'(sat_a), 32'(msat_a));
    chk("match_b", 32'(match_b), 32'(hit));
    chk("count_b", 32'(cnt_b), 32'(mcnt_b));
    chk("sat_b",   32'(sat_b), 32'(msat_b));
  endtask

  task automatic bits(input logic [31:0] s, input int n, input bit ov);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, s[i], ov, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
  endtask

  initial begin
    bit         cur_ov;
    int         r;
    logic [3:0] rp;

    do_reset();
    do_reset();
    chk("rst_match", 32'(match_a), 32'd0);
    chk("rst_count", 32'(cnt_a), 32'd0);

    // Overlapping: 1011011 gives two hits.
    bits(32'b1011011, 7, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    chk("ovl_count", 32'(cnt_a), 32'd2);

    // Non-overlapping: same stream gives one hit.
    do_reset();
    bits(32'b1011011, 7, 1'b0);
    chk("novl_count", 32'(cnt_a), 32'd1);

    // Valid gap between bits.
    do_reset();
    bits(32'b10, 2, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    bits(32'b11, 2, 1'b1);
    chk("gap_match", 32'(match_a), 32'd1);
    chk("gap_count", 32'(cnt_a), 32'd1);

    // Reload mid-stream: same-cycle bit is discarded, old pattern stops matching.
    do_reset();
    bits(32'b101, 3, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
    chk("load_nomatch", 32'(match_a), 32'd0);
    bits(32'b1011, 4, 1'b1);
    chk("old_pat_count", 32'(cnt_a), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0110, 1'b0);
    bits(32'b0110, 4, 1'b1);
    chk("new_pat_match", 32'(match_a), 32'd1);

    // Saturation on the 2-bit counter, then clear colliding with a hit.
    do_reset();
    for (int k = 0; k < 4; k++) bits(32'b1011, 4, 1'b0);
    chk("sat_count_b", 32'(cnt_b), 32'd3);
    chk("sat_flag_b", 32'(sat_b), 32'd1);
    chk("nosat_count_a", 32'(cnt_a), 32'd4);
    bits(32'b101, 3, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1);
    chk("clr_hit_match", 32'(match_b), 32'd1);
    chk("clr_hit_count", 32'(cnt_b), 32'd0);
    chk("clr_hit_sat", 32'(sat_b), 32'd0);

    // Reset mid-pattern discards the partial bits.
    bits(32'b101, 3, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    chk("rst_mid_match", 32'(match_a), 32'd0);
    bits(32'b1, 1, 1'b1);
    chk("rst_mid_nomatch", 32'(match_a), 32'd0);

    // Random stream against the model.
    cur_ov = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      r  = int'($urandom_range(0, 99));
      rp = 4'($urandom);
      step(r == 0, $urandom_range(0, 9) != 0, bit'($urandom_range(0, 1)), cur_ov,
           (r >= 1) && (r <= 3), rp, (r == 4) || (r == 5));
      if ($urandom_range(0, 49) == 0) cur_ov = ~cur_ov;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
